// File: rtl/ysyx_23060096_imm_gen_pipe_if.sv
// Handshake bundle between the ID-stage instruction source and the immediate generator.
// master = instruction producer / immediate consumer, slave = the generator itself.
interface ysyx_23060096_imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [2:0]       in_extop;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;

  modport master (
    output in_valid, in_inst, in_extop, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag, out_err
  );

  modport slave (
    input  in_valid, in_inst, in_extop, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag, out_err
  );
endinterface

// File: rtl/ysyx_23060096_imm_gen_pipe.sv
// Pipelined immediate generator: 1-cycle latency, output register plus one skid entry
// so a stalled consumer never loses a beat; in_ready drops only while the skid is occupied.
module ysyx_23060096_imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic clk,
  input  logic rstn,
  input  logic flush,
  ysyx_23060096_imm_gen_pipe_if.slave bus
);

  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  out_imm_q,   out_imm_d;
  logic [TAG_W-1:0] out_tag_q,   out_tag_d;
  logic             out_err_q,   out_err_d;
  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q,   skid_imm_d;
  logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;
  logic             skid_err_q,   skid_err_d;

  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [XLEN-1:0] new_imm;
  logic new_err;
  logic accept;
  logic out_load;
  logic unused_bits;

  // Every format is first formed as a 32-bit value whose bit 31 is the sign,
  // then sign-extended once; zero-extended formats simply keep bit 31 clear.
  always_comb begin
    imm32   = '0;
    new_err = 1'b0;
    case (bus.in_extop)
      3'b000: imm32 = {{20{bus.in_inst[31]}}, bus.in_inst[31:20]};
      3'b001: imm32 = {bus.in_inst[31:12], 12'b0};
      3'b010: imm32 = {{20{bus.in_inst[31]}}, bus.in_inst[31:25], bus.in_inst[11:7]};
      3'b011: imm32 = {{19{bus.in_inst[31]}}, bus.in_inst[31], bus.in_inst[7],
                       bus.in_inst[30:25], bus.in_inst[11:8], 1'b0};
      3'b100: imm32 = {{11{bus.in_inst[31]}}, bus.in_inst[31], bus.in_inst[19:12],
                       bus.in_inst[20], bus.in_inst[30:21], 1'b0};
      3'b101: imm32 = {27'b0, bus.in_inst[19:15]};
      3'b110: begin
        if (XLEN == 64) begin
          imm32 = {26'b0, bus.in_inst[25:20]};
        end else if (bus.in_inst[25]) begin
          new_err = 1'b1;
        end else begin
          imm32 = {27'b0, bus.in_inst[24:20]};
        end
      end
      default: new_err = 1'b1;
    endcase
  end

  assign imm64   = {{32{imm32[31]}}, imm32};
  assign new_imm = imm64[XLEN-1:0];
  assign unused_bits = ^{bus.in_inst[6:0], imm64[63:32]};

  assign out_load = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && !skid_valid_q && !flush;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    out_tag_d    = out_tag_q;
    out_err_d    = out_err_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_tag_d   = skid_tag_q;
    skid_err_d   = skid_err_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_load) begin
      // A waiting skid entry always drains first; no accept can coincide since in_ready was low.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_imm_d    = skid_imm_q;
        out_tag_d    = skid_tag_q;
        out_err_d    = skid_err_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) begin
          out_imm_d = new_imm;
          out_tag_d = bus.in_tag;
          out_err_d = new_err;
        end
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = new_imm;
      skid_tag_d   = bus.in_tag;
      skid_err_d   = new_err;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_tag_q    <= '0;
      out_err_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_tag_q   <= '0;
      skid_err_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      out_tag_q    <= out_tag_d;
      out_err_q    <= out_err_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_tag_q   <= skid_tag_d;
      skid_err_q   <= skid_err_d;
    end
  end

  assign bus.in_ready  = !skid_valid_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_imm   = out_imm_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_ysyx_23060096_imm_gen_pipe.sv
// Directed checks of both XLEN builds plus a random-handshake ordering run.
module tb_ysyx_23060096_imm_gen_pipe;
  logic clk = 1'b0;
  logic rstn;
  logic flush;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_23060096_imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) b32 ();
  ysyx_23060096_imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) b64 ();

  ysyx_23060096_imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .rstn(rstn), .flush(flush), .bus(b32.slave));
  ysyx_23060096_imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rstn(rstn), .flush(flush), .bus(b64.slave));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One instruction through an idle pipe; checked the cycle after acceptance.
  task automatic beat(input bit w64, input string tag, input logic [31:0] inst,
                      input logic [2:0] op, input logic [63:0] exp_imm, input logic exp_err);
    @(negedge clk);
    if (w64) begin
      b64.in_valid = 1'b1; b64.in_inst = inst; b64.in_extop = op; b64.in_tag = 32'h55;
    end else begin
      b32.in_valid = 1'b1; b32.in_inst = inst; b32.in_extop = op; b32.in_tag = 32'h55;
    end
    @(negedge clk);
    if (w64) begin
      check_eq({tag, "_vld"}, 64'(b64.out_valid), 64'd1);
      check_eq({tag, "_imm"}, b64.out_imm, exp_imm);
      check_eq({tag, "_err"}, 64'(b64.out_err), 64'(exp_err));
      b64.in_valid = 1'b0;
    end else begin
      check_eq({tag, "_vld"}, 64'(b32.out_valid), 64'd1);
      check_eq({tag, "_imm"}, 64'(b32.out_imm), exp_imm);
      check_eq({tag, "_err"}, 64'(b32.out_err), 64'(exp_err));
      b32.in_valid = 1'b0;
    end
  endtask

  // Leaves dut32 with tag 1 in the output register and tag 2 in the skid.
  task automatic fill32();
    @(negedge clk);
    b32.out_ready = 1'b0;
    b32.in_valid = 1'b1; b32.in_inst = 32'hFE000EE3; b32.in_extop = 3'b011; b32.in_tag = 32'd1;
    @(negedge clk);
    b32.in_tag = 32'd2;
    @(negedge clk);
    b32.in_tag = 32'd3;
  endtask

  logic [63:0] exp_tag_q[$];
  logic [63:0] exp_imm_q[$];
  int sent, rcvd;
  bit acc;
  logic [31:0] rinst;

  initial begin
    rstn = 1'b0; flush = 1'b0;
    b32.in_valid = 1'b0; b32.in_inst = '0; b32.in_extop = '0; b32.in_tag = '0; b32.out_ready = 1'b1;
    b64.in_valid = 1'b0; b64.in_inst = '0; b64.in_extop = '0; b64.in_tag = '0; b64.out_ready = 1'b1;
    #12;
    check_eq("rst_vld32", 64'(b32.out_valid), 64'd0);
    check_eq("rst_rdy32", 64'(b32.in_ready), 64'd1);
    check_eq("rst_imm64", b64.out_imm, 64'd0);
    check_eq("rst_err64", 64'(b64.out_err), 64'd0);
    @(negedge clk);
    rstn = 1'b1;

    beat(1'b1, "i64",   32'hFFF00093, 3'b000, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    beat(1'b1, "u64",   32'h800000B7, 3'b001, 64'hFFFFFFFF80000000, 1'b0);
    beat(1'b0, "j32",   32'h0010006F, 3'b100, 64'h00000800, 1'b0);
    beat(1'b0, "i32",   32'h7FF00093, 3'b000, 64'h000007FF, 1'b0);
    beat(1'b0, "u32",   32'h12345037, 3'b001, 64'h12345000, 1'b0);
    beat(1'b0, "s32",   32'hFE112E23, 3'b010, 64'hFFFFFFFC, 1'b0);
    beat(1'b0, "z32",   32'h000F8073, 3'b101, 64'h0000001F, 1'b0);
    beat(1'b1, "sh64",  32'h03F00013, 3'b110, 64'h3F, 1'b0);
    beat(1'b0, "sh32e", 32'h02000013, 3'b110, 64'h0, 1'b1);
    beat(1'b0, "rsv32", 32'hFFFFFFFF, 3'b111, 64'h0, 1'b1);

    // Backpressure: third beat is held off until the consumer drains.
    fill32();
    check_eq("bp_rdy_low", 64'(b32.in_ready), 64'd0);
    @(negedge clk);
    check_eq("bp_hold_rdy", 64'(b32.in_ready), 64'd0);
    check_eq("bp_tag1", 64'(b32.out_tag), 64'd1);
    check_eq("bp_imm1", 64'(b32.out_imm), 64'hFFFFFFFC);
    b32.out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_tag2", 64'(b32.out_tag), 64'd2);
    check_eq("bp_imm2", 64'(b32.out_imm), 64'hFFFFFFFC);
    check_eq("bp_rdy_back", 64'(b32.in_ready), 64'd1);
    @(negedge clk);
    check_eq("bp_tag3", 64'(b32.out_tag), 64'd3);
    check_eq("bp_imm3", 64'(b32.out_imm), 64'hFFFFFFFC);
    b32.in_valid = 1'b0;
    @(negedge clk);
    check_eq("bp_drained", 64'(b32.out_valid), 64'd0);

    // Flush with both stages full and an input still offered.
    fill32();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    b32.in_valid = 1'b0;
    check_eq("fl_vld", 64'(b32.out_valid), 64'd0);
    check_eq("fl_rdy", 64'(b32.in_ready), 64'd1);
    b32.out_ready = 1'b1;
    @(negedge clk);
    check_eq("fl_nothing", 64'(b32.out_valid), 64'd0);

    // Asynchronous reset with both stages full.
    fill32();
    #2 rstn = 1'b0;
    #1;
    check_eq("ar_vld", 64'(b32.out_valid), 64'd0);
    check_eq("ar_imm", 64'(b32.out_imm), 64'd0);
    check_eq("ar_tag", 64'(b32.out_tag), 64'd0);
    check_eq("ar_rdy", 64'(b32.in_ready), 64'd1);
    b32.in_valid = 1'b0;
    b32.out_ready = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check_eq("ar_no_beat", 64'(b32.out_valid), 64'd0);

    // Random valid/ready against an in-order queue model of I-type immediates.
    sent = 0; rcvd = 0; acc = 1'b0;
    for (int cyc = 0; cyc < 5000 && (sent < 300 || exp_tag_q.size() > 0); cyc++) begin
      @(negedge clk);
      if (!b32.in_valid || acc) begin
        if (sent < 300 && $urandom_range(0, 3) != 0) begin
          rinst = $urandom;
          b32.in_valid = 1'b1; b32.in_inst = rinst; b32.in_extop = 3'b000; b32.in_tag = sent;
        end else begin
          b32.in_valid = 1'b0;
        end
      end
      b32.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc = b32.in_valid && b32.in_ready;
      if (acc) begin
        exp_tag_q.push_back(64'(b32.in_tag));
        exp_imm_q.push_back(64'({{20{b32.in_inst[31]}}, b32.in_inst[31:20]}));
        sent++;
      end
      if (b32.out_valid && b32.out_ready) begin
        if (exp_tag_q.size() == 0) begin
          check_eq("rnd_spurious", 64'(exp_tag_q.size()), 64'd1);
        end else begin
          check_eq("rnd_tag", 64'(b32.out_tag), exp_tag_q.pop_front());
          check_eq("rnd_imm", 64'(b32.out_imm), exp_imm_q.pop_front());
          rcvd++;
        end
      end
    end
    b32.in_valid = 1'b0;
    check_eq("rnd_count", 64'(rcvd), 64'd300);
    check_eq("rnd_left", 64'(exp_tag_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
